// File: rtl/ps2_pkg.sv
// PS/2 set-2 keyboard decoding: shared scancode constants, frame states and lookup helpers.
package ps2_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;

  typedef enum logic [1:0] {
    FR_IDLE,
    FR_DATA,
    FR_PARITY,
    FR_STOP
  } frame_state_e;

  // Set-2 make code to ASCII; returns {mapped, ascii}.
  function automatic logic [8:0] sc2ascii(input logic [7:0] code);
    logic [8:0] r;
    case (code)
      8'h45:   r = {1'b1, 8'h30};
      8'h16:   r = {1'b1, 8'h31};
      8'h1E:   r = {1'b1, 8'h32};
      8'h26:   r = {1'b1, 8'h33};
      8'h25:   r = {1'b1, 8'h34};
      8'h2E:   r = {1'b1, 8'h35};
      8'h36:   r = {1'b1, 8'h36};
      8'h3D:   r = {1'b1, 8'h37};
      8'h3E:   r = {1'b1, 8'h38};
      8'h46:   r = {1'b1, 8'h39};
      8'h1C:   r = {1'b1, 8'h41};
      8'h32:   r = {1'b1, 8'h42};
      8'h21:   r = {1'b1, 8'h43};
      8'h23:   r = {1'b1, 8'h44};
      8'h24:   r = {1'b1, 8'h45};
      8'h2B:   r = {1'b1, 8'h46};
      8'h5A:   r = {1'b1, 8'h0D};
      8'h66:   r = {1'b1, 8'h08};
      default: r = 9'h000;
    endcase
    return r;
  endfunction

  // ASCII to hex nibble; returns {is_hex, nibble}, nibble forced to 0 when not a hex digit.
  function automatic logic [4:0] ascii2hex(input logic [7:0] a);
    logic [4:0] r;
    logic [7:0] t;
    r = 5'h00;
    t = 8'h00;
    if (a >= 8'h30 && a <= 8'h39) begin
      t = a - 8'h30;
      r = {1'b1, t[3:0]};
    end else if (a >= 8'h41 && a <= 8'h46) begin
      t = a - 8'h37;
      r = {1'b1, t[3:0]};
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: input synchronisers, ps2_clk fall detect, 11-bit frame FSM with odd-parity/stop checks and inactivity timeout.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic                   prev_clk_q;
  frame_state_e           state_q, state_d;
  logic [2:0]             bitcnt_q, bitcnt_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic [7:0]             shreg_q, shreg_d;
  logic                   parity_q, parity_d;
  logic [7:0]             byte_q, byte_d;
  logic                   byte_valid_q, byte_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   sync_clk, sync_data, fall;

  assign sync_clk  = clk_sync_q[SYNC_STAGES-1];
  assign sync_data = data_sync_q[SYNC_STAGES-1];
  // Chain resets low so an idle-high line after reset is seen as a rise, never a fall.
  assign fall      = prev_clk_q & ~sync_clk;

  // Synchronise both PS/2 lines into clk and remember the previous synced clock level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync_q  <= '0;
      data_sync_q <= '0;
      prev_clk_q  <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
      prev_clk_q  <= sync_clk;
    end
  end

  // Frame FSM: every step happens on a ps2_clk fall; timeout aborts a stalled partial frame.
  always_comb begin
    state_d      = state_q;
    bitcnt_d     = bitcnt_q;
    shreg_d      = shreg_q;
    parity_d     = parity_q;
    byte_d       = byte_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    tmo_d        = (state_q == FR_IDLE || fall) ? '0 : tmo_q + TMO_W'(1);
    if (fall) begin
      case (state_q)
        FR_IDLE: begin
          if (!sync_data) begin
            state_d  = FR_DATA;
            bitcnt_d = 3'd0;
          end
        end
        FR_DATA: begin
          shreg_d  = {sync_data, shreg_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = FR_PARITY;
        end
        FR_PARITY: begin
          parity_d = sync_data;
          state_d  = FR_STOP;
        end
        FR_STOP: begin
          if (sync_data && (^{shreg_q, parity_q})) begin
            byte_valid_d = 1'b1;
            byte_d       = shreg_q;
          end else begin
            frame_err_d  = 1'b1;
          end
          state_d = FR_IDLE;
        end
        default: state_d = FR_IDLE;
      endcase
    end else if (state_q != FR_IDLE && tmo_q == TMO_LAST) begin
      state_d     = FR_IDLE;
      frame_err_d = 1'b1;
    end
  end

  // Control state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= FR_IDLE;
      bitcnt_q     <= 3'd0;
      tmo_q        <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bitcnt_q     <= bitcnt_d;
      tmo_q        <= tmo_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Data registers; only consumed when qualified by byte_valid.
  always_ff @(posedge clk) begin
    shreg_q  <= shreg_d;
    parity_q <= parity_d;
    byte_q   <= byte_d;
  end

  assign data_byte  = byte_q;
  assign byte_valid = byte_valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder top: turns received set-2 bytes into a single held-key flag plus ASCII/hex outputs.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_state,
  output logic [7:0] key_ascii,
  output logic [3:0] key_hex,
  output logic       key_is_hex,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       mapped;
  logic [7:0] map_ascii;
  logic       map_is_hex;
  logic [3:0] map_hex;

  logic       key_state_q, key_state_d;
  logic [7:0] key_ascii_q, key_ascii_d;
  logic [3:0] key_hex_q, key_hex_d;
  logic       key_is_hex_q, key_is_hex_d;
  logic [7:0] held_code_q, held_code_d;
  logic       ext_q, ext_d;
  logic       brk_q, brk_d;

  ps2_rx_frame #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_rx (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .data_byte  (rx_byte),
    .byte_valid (rx_valid),
    .frame_err  (frame_err)
  );

  assign {mapped, map_ascii}   = sc2ascii(rx_byte);
  assign {map_is_hex, map_hex} = ascii2hex(map_ascii);

  // Scancode FSM: prefix flags plus single-key make/break tracking; ascii only changes on a fresh make.
  always_comb begin
    key_state_d  = key_state_q;
    key_ascii_d  = key_ascii_q;
    key_hex_d    = key_hex_q;
    key_is_hex_d = key_is_hex_q;
    held_code_d  = held_code_q;
    ext_d        = ext_q;
    brk_d        = brk_q;
    if (rx_valid) begin
      if (rx_byte == SC_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte == SC_BREAK) begin
        brk_d = 1'b1;
      end else if (ext_q) begin
        // Extended keys are not supported: drop the whole sequence.
        ext_d = 1'b0;
        brk_d = 1'b0;
      end else if (brk_q) begin
        if (key_state_q && rx_byte == held_code_q) key_state_d = 1'b0;
        brk_d = 1'b0;
      end else if (!key_state_q && mapped) begin
        // Repeats and roll-over while a key is held fall through here untouched.
        key_ascii_d  = map_ascii;
        key_hex_d    = map_hex;
        key_is_hex_d = map_is_hex;
        held_code_d  = rx_byte;
        key_state_d  = 1'b1;
      end
    end
  end

  // Decoder state and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_state_q  <= 1'b0;
      key_ascii_q  <= 8'h00;
      key_hex_q    <= 4'h0;
      key_is_hex_q <= 1'b0;
      held_code_q  <= 8'h00;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
    end else begin
      key_state_q  <= key_state_d;
      key_ascii_q  <= key_ascii_d;
      key_hex_q    <= key_hex_d;
      key_is_hex_q <= key_is_hex_d;
      held_code_q  <= held_code_d;
      ext_q        <= ext_d;
      brk_q        <= brk_d;
    end
  end

  assign key_state  = key_state_q;
  assign key_ascii  = key_ascii_q;
  assign key_hex    = key_hex_q;
  assign key_is_hex = key_is_hex_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: PS/2 frames in, key_state edges and frame_err pulses checked against queued expectations.
`timescale 1ns/1ps
module tb_ps2_key_decoder;

  localparam int EV_RISE = 1;
  localparam int EV_FALL = 2;
  localparam int EV_ERR  = 3;

  typedef struct {
    int         kind;
    logic [7:0] ascii;
    logic [3:0] hex;
    logic       is_hex;
    int         lat;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       key_state;
  logic [7:0] key_ascii;
  logic [3:0] key_hex;
  logic       key_is_hex;
  logic       frame_err;

  ev_t  sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  time  stop_t = 0;
  logic ks_prev = 1'b0;

  ps2_key_decoder #(
    .TIMEOUT_CYCLES (200),
    .SYNC_STAGES    (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .key_state  (key_state),
    .key_ascii  (key_ascii),
    .key_hex    (key_hex),
    .key_is_hex (key_is_hex),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic exp_rise(input logic [7:0] a, input logic [3:0] h, input logic ih);
    ev_t e;
    e.kind = EV_RISE; e.ascii = a; e.hex = h; e.is_hex = ih; e.lat = 40;
    sb.push_back(e);
  endtask

  task automatic exp_fall(input logic [7:0] a, input int lat);
    ev_t e;
    e.kind = EV_FALL; e.ascii = a; e.hex = 4'h0; e.is_hex = 1'b0; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic exp_err(input int lat);
    ev_t e;
    e.kind = EV_ERR; e.ascii = 8'h00; e.hex = 4'h0; e.is_hex = 1'b0; e.lat = lat;
    sb.push_back(e);
  endtask

  // Drive the first n bits of a frame (bits[0] first), 20 clk per half period.
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      wait_clk(20);
      ps2_clk = 1'b0;
      if (i == 10) stop_t = $time;
      wait_clk(20);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    logic p;
    p = (~^b) ^ bad_par;
    send_bits({~bad_stop, p, b, 1'b0}, 11);
    wait_clk(40);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0);
  endtask

  task automatic handle(input int kind);
    ev_t e;
    if (sb.size() == 0) begin
      chk("sb_underflow", sb.size(), 1);
    end else begin
      e = sb.pop_front();
      chk("ev_kind", kind, e.kind);
      if (e.kind == EV_RISE) begin
        chk("rise_ascii", key_ascii, e.ascii);
        chk("rise_hex", key_hex, e.hex);
        chk("rise_is_hex", key_is_hex, e.is_hex);
      end
      if (e.kind == EV_FALL) chk("fall_ascii", key_ascii, e.ascii);
      if (e.lat != 0) chk("latency_ns", 32'($time - stop_t), e.lat);
    end
  endtask

  // Monitor: sample outputs on the falling clk edge, away from the active edge.
  always @(negedge clk) begin
    if (key_state && !ks_prev) handle(EV_RISE);
    if (!key_state && ks_prev) handle(EV_FALL);
    if (frame_err) handle(EV_ERR);
    ks_prev = key_state;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit, queue depth %0d", sb.size());
    $fatal(1);
  end

  initial begin
    wait_clk(5);
    chk("rst_key_state", key_state, 0);
    chk("rst_key_ascii", key_ascii, 0);
    chk("rst_key_hex", key_hex, 0);
    chk("rst_key_is_hex", key_is_hex, 0);
    chk("rst_frame_err", frame_err, 0);
    reset = 1'b0;
    wait_clk(10);

    // '1' press and release
    exp_rise(8'h31, 4'h1, 1'b1);
    send(8'h16);
    exp_fall(8'h31, 40);
    send(8'hF0); send(8'h16);

    // 'A' with typematic repeats
    exp_rise(8'h41, 4'hA, 1'b1);
    send(8'h1C); send(8'h1C); send(8'h1C);
    exp_fall(8'h41, 40);
    send(8'hF0); send(8'h1C);

    // bad parity, then normal decode
    exp_err(30);
    send_frame(8'h16, 1'b1, 1'b0);
    chk("par_key_state", key_state, 0);
    exp_rise(8'h31, 4'h1, 1'b1);
    send(8'h16);
    exp_fall(8'h31, 40);
    send(8'hF0); send(8'h16);

    // bad stop bit
    exp_err(30);
    send_frame(8'h45, 1'b0, 1'b1);
    chk("stop_key_state", key_state, 0);

    // timeout on a partial frame, then '0'
    exp_err(0);
    send_bits({1'b1, ~^8'h16, 8'h16, 1'b0}, 6);
    wait_clk(300);
    exp_rise(8'h30, 4'h0, 1'b1);
    send(8'h45);
    exp_fall(8'h30, 40);
    send(8'hF0); send(8'h45);

    // extended arrow make/break and an unmapped key are ignored; then Enter
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'h1A);
    chk("ign_key_state", key_state, 0);
    exp_rise(8'h0D, 4'h0, 1'b0);
    send(8'h5A);
    exp_fall(8'h0D, 40);
    send(8'hF0); send(8'h5A);

    // reset mid-frame while Backspace is held
    exp_rise(8'h08, 4'h0, 1'b0);
    send(8'h66);
    send_bits({1'b1, ~^8'h26, 8'h26, 1'b0}, 4);
    wait_clk(10);
    exp_fall(8'h00, 0);
    reset = 1'b1;
    #1;
    chk("mid_rst_key_state", key_state, 0);
    chk("mid_rst_key_ascii", key_ascii, 0);
    chk("mid_rst_key_hex", key_hex, 0);
    chk("mid_rst_key_is_hex", key_is_hex, 0);
    chk("mid_rst_frame_err", frame_err, 0);
    wait_clk(4);
    reset = 1'b0;
    wait_clk(10);

    // '3' after reset; a break for another key does not release it
    exp_rise(8'h33, 4'h3, 1'b1);
    send(8'h26);
    send(8'hF0); send(8'h16);
    chk("other_brk_key_state", key_state, 1);
    exp_fall(8'h33, 40);
    send(8'hF0); send(8'h26);

    wait_clk(50);
    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
